// File: rtl/dual_clk_sched_if.sv
// Bundles the start/stop control, run configuration and the divided-clock,
// tick and status outputs of dual_clk_sched. The hold input exists only when DUAL_CLK_SCHED_HOLD_EN is defined.
interface dual_clk_sched_if #(
    parameter int CNT_W = 8,
    parameter int DUR_W = 16
);
    logic             i_start;
    logic             i_stop;
`ifdef DUAL_CLK_SCHED_HOLD_EN
    logic             i_hold;
`endif
    logic [CNT_W-1:0] i_half0;
    logic [CNT_W-1:0] i_half1;
    logic [DUR_W-1:0] i_duration;
    logic             o_clk_out0;
    logic             o_clk_out1;
    logic             o_tick0;
    logic             o_tick1;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

`ifdef DUAL_CLK_SCHED_HOLD_EN
    modport master (
        output i_start, i_stop, i_hold, i_half0, i_half1, i_duration,
        input  o_clk_out0, o_clk_out1, o_tick0, o_tick1, o_busy, o_done, o_err
    );
    modport slave (
        input  i_start, i_stop, i_hold, i_half0, i_half1, i_duration,
        output o_clk_out0, o_clk_out1, o_tick0, o_tick1, o_busy, o_done, o_err
    );
`else
    modport master (
        output i_start, i_stop, i_half0, i_half1, i_duration,
        input  o_clk_out0, o_clk_out1, o_tick0, o_tick1, o_busy, o_done, o_err
    );
    modport slave (
        input  i_start, i_stop, i_half0, i_half1, i_duration,
        output o_clk_out0, o_clk_out1, o_tick0, o_tick1, o_busy, o_done, o_err
    );
`endif
endinterface

// File: rtl/dual_clk_sched.sv
// Two-channel divided-clock scheduler: runs two programmable square waves for a programmed number of cycles.
// Optional pause/resume via the hold input when DUAL_CLK_SCHED_HOLD_EN is defined.
//   state  | meaning
//   IDLE   | waiting for a valid start; outputs held low
//   RUN    | channels counting, elapsed advancing
//   HOLD   | counters frozen, clocks held, ticks low (hold build only)
module dual_clk_sched #(
    parameter int CNT_W = 8,
    parameter int DUR_W = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    dual_clk_sched_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
`ifdef DUAL_CLK_SCHED_HOLD_EN
        ,
        S_HOLD = 2'd2
`endif
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_half0_q;
    logic [CNT_W-1:0] r_half1_q;
    logic [DUR_W-1:0] r_dur_q;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic [DUR_W-1:0] r_elapsed;
    logic             r_clk_out0;
    logic             r_clk_out1;
    logic             r_tick0;
    logic             r_tick1;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_half0_nxt;
    logic [CNT_W-1:0] w_half1_nxt;
    logic [DUR_W-1:0] w_dur_nxt;
    logic [CNT_W-1:0] w_cnt0_nxt;
    logic [CNT_W-1:0] w_cnt1_nxt;
    logic [DUR_W-1:0] w_elapsed_nxt;
    logic             w_clk_out0_nxt;
    logic             w_clk_out1_nxt;
    logic             w_tick0_nxt;
    logic             w_tick1_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_cfg_ok;

    assign w_cfg_ok = (bus.i_half0 != '0) && (bus.i_half1 != '0) && (bus.i_duration != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_half0_q  <= '0;
            r_half1_q  <= '0;
            r_dur_q    <= '0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
            r_elapsed  <= '0;
            r_clk_out0 <= 1'b0;
            r_clk_out1 <= 1'b0;
            r_tick0    <= 1'b0;
            r_tick1    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_half0_q  <= w_half0_nxt;
            r_half1_q  <= w_half1_nxt;
            r_dur_q    <= w_dur_nxt;
            r_cnt0     <= w_cnt0_nxt;
            r_cnt1     <= w_cnt1_nxt;
            r_elapsed  <= w_elapsed_nxt;
            r_clk_out0 <= w_clk_out0_nxt;
            r_clk_out1 <= w_clk_out1_nxt;
            r_tick0    <= w_tick0_nxt;
            r_tick1    <= w_tick1_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_half0_nxt    = r_half0_q;
        w_half1_nxt    = r_half1_q;
        w_dur_nxt      = r_dur_q;
        w_cnt0_nxt     = r_cnt0;
        w_cnt1_nxt     = r_cnt1;
        w_elapsed_nxt  = r_elapsed;
        w_clk_out0_nxt = r_clk_out0;
        w_clk_out1_nxt = r_clk_out1;
        w_tick0_nxt    = 1'b0;
        w_tick1_nxt    = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_out0_nxt = 1'b0;
                w_clk_out1_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
                if (bus.i_start && !bus.i_stop) begin
                    if (w_cfg_ok) begin
                        w_half0_nxt   = bus.i_half0;
                        w_half1_nxt   = bus.i_half1;
                        w_dur_nxt     = bus.i_duration;
                        w_cnt0_nxt    = bus.i_half0 - CNT_W'(1);
                        w_cnt1_nxt    = bus.i_half1 - CNT_W'(1);
                        w_elapsed_nxt = '0;
                        w_busy_nxt    = 1'b1;
                        w_state_nxt   = S_RUN;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            // RUN, and HOLD being released, both advance one run edge here
            default: begin
                if (bus.i_stop) begin
                    w_state_nxt    = S_IDLE;
                    w_clk_out0_nxt = 1'b0;
                    w_clk_out1_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
`ifdef DUAL_CLK_SCHED_HOLD_EN
                end else if (bus.i_hold) begin
                    w_state_nxt = S_HOLD;
`endif
                end else if (r_elapsed == r_dur_q - DUR_W'(1)) begin
                    w_state_nxt    = S_IDLE;
                    w_clk_out0_nxt = 1'b0;
                    w_clk_out1_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                end else begin
                    w_state_nxt   = S_RUN;
                    w_elapsed_nxt = r_elapsed + DUR_W'(1);
                    if (r_cnt0 == '0) begin
                        w_clk_out0_nxt = ~r_clk_out0;
                        w_tick0_nxt    = 1'b1;
                        w_cnt0_nxt     = r_half0_q - CNT_W'(1);
                    end else begin
                        w_cnt0_nxt = r_cnt0 - CNT_W'(1);
                    end
                    if (r_cnt1 == '0) begin
                        w_clk_out1_nxt = ~r_clk_out1;
                        w_tick1_nxt    = 1'b1;
                        w_cnt1_nxt     = r_half1_q - CNT_W'(1);
                    end else begin
                        w_cnt1_nxt = r_cnt1 - CNT_W'(1);
                    end
                end
            end
        endcase
    end

    assign bus.o_clk_out0 = r_clk_out0;
    assign bus.o_clk_out1 = r_clk_out1;
    assign bus.o_tick0    = r_tick0;
    assign bus.o_tick1    = r_tick1;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_err      = r_err;
endmodule

// File: tb/tb_dual_clk_sched.sv
// Randomized and directed bench for dual_clk_sched against an arithmetic reference model.
// Pause/resume scenarios are included when DUAL_CLK_SCHED_HOLD_EN is defined.
module tb_dual_clk_sched;
`ifdef DUAL_CLK_SCHED_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_clk_sched_if #(.CNT_W(8), .DUR_W(16)) bus ();
    dual_clk_sched #(.CNT_W(8), .DUR_W(16)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // reference model: a run is described by its halves, duration and count of run edges taken
    bit m_act = 1'b0;
    bit m_held, m_done, m_err;
    int m_j, m_h0, m_h1, m_d;
    int n_tick0, n_tick1, n_done, done_edge;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] model_outs();
        logic c0, c1, t0, t1;
        c0 = 1'b0; c1 = 1'b0; t0 = 1'b0; t1 = 1'b0;
        if (m_act) begin
            c0 = ((m_j / m_h0) % 2) == 1;
            c1 = ((m_j / m_h1) % 2) == 1;
            t0 = !m_held && m_j > 0 && (m_j % m_h0) == 0;
            t1 = !m_held && m_j > 0 && (m_j % m_h1) == 0;
        end
        return {c0, c1, t0, t1, m_act, m_done, m_err};
    endfunction

    task automatic set_cfg(input int h0, input int h1, input int d);
        bus.i_half0    = 8'(h0);
        bus.i_half1    = 8'(h1);
        bus.i_duration = 16'(d);
    endtask

    task automatic step(input bit st, input bit sp, input bit hd, input bit rs, input string tag);
        bus.i_start = st;
        bus.i_stop  = sp;
`ifdef DUAL_CLK_SCHED_HOLD_EN
        bus.i_hold  = hd;
`endif
        rst = rs;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_held = 1'b0;
        if (rs) begin
            m_act = 1'b0;
        end else if (m_act) begin
            if (sp) m_act = 1'b0;
            else if (HOLD_EN && hd) m_held = 1'b1;
            else begin
                m_j++;
                if (m_j == m_d) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (st && !sp) begin
            if (bus.i_half0 != 0 && bus.i_half1 != 0 && bus.i_duration != 0) begin
                m_act = 1'b1;
                m_j   = 0;
                m_h0  = int'(bus.i_half0);
                m_h1  = int'(bus.i_half1);
                m_d   = int'(bus.i_duration);
            end else begin
                m_err = 1'b1;
            end
        end
        check_eq(tag, {bus.o_clk_out0, bus.o_clk_out1, bus.o_tick0, bus.o_tick1,
                       bus.o_busy, bus.o_done, bus.o_err}, model_outs());
        n_tick0 += int'(bus.o_tick0);
        n_tick1 += int'(bus.o_tick1);
        n_done  += int'(bus.o_done);
    endtask

    task automatic clr_counts();
        n_tick0 = 0; n_tick1 = 0; n_done = 0; done_edge = -1;
    endtask

    // scramble config inputs while running; the latched copy must not change
    task automatic scramble();
        set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 50));
    endtask

    initial begin
        set_cfg(0, 0, 0);
        step(0, 0, 0, 1, "reset0");
        step(0, 0, 0, 1, "reset1");

        // base run
        clr_counts();
        set_cfg(2, 3, 24);
        step(1, 0, 0, 0, "base_e0");
        for (int e = 1; e <= 24; e++) begin
            scramble();
            step(1, 0, 0, 0, $sformatf("base_e%0d", e));
        end
        check_eq("base_tick0_cnt", n_tick0, 11);
        check_eq("base_tick1_cnt", n_tick1, 7);
        check_eq("base_done_cnt", n_done, 1);
        check_eq("base_busy_end", bus.o_busy, 1'b0);

        // coincident toggle at edge 6
        set_cfg(2, 3, 20);
        step(1, 0, 0, 0, "coinc_e0");
        for (int e = 1; e <= 20; e++) begin
            step(0, 0, 0, 0, $sformatf("coinc_e%0d", e));
            if (e == 6)
                check_eq("coinc_e6_pins", {bus.o_tick0, bus.o_tick1, bus.o_clk_out0, bus.o_clk_out1}, 4'b1110);
        end

        // invalid config and start+stop collision
        set_cfg(2, 0, 10);
        step(1, 0, 0, 0, "inval_start");
        step(0, 0, 0, 0, "inval_after");
        set_cfg(2, 3, 10);
        step(1, 1, 0, 0, "start_stop_same");
        step(0, 0, 0, 0, "start_stop_after");

        // abort at edge 10, restart at edge 12
        clr_counts();
        set_cfg(1, 4, 100);
        step(1, 0, 0, 0, "abort_e0");
        for (int e = 1; e <= 9; e++) step(0, 0, 0, 0, $sformatf("abort_e%0d", e));
        step(0, 1, 0, 0, "abort_e10");
        step(0, 0, 0, 0, "abort_e11");
        step(1, 0, 0, 0, "abort_e12");
        check_eq("abort_restart_busy", bus.o_busy, 1'b1);
        step(0, 1, 0, 0, "abort_e13");
        check_eq("abort_done_cnt", n_done, 0);

        // reset mid-run at edge 7
        clr_counts();
        set_cfg(2, 3, 24);
        step(1, 0, 0, 0, "rstmid_e0");
        for (int e = 1; e <= 6; e++) step(0, 0, 0, 0, $sformatf("rstmid_e%0d", e));
        step(0, 0, 0, 1, "rstmid_e7");
        for (int e = 8; e <= 30; e++) step(0, 0, 0, 0, $sformatf("rstmid_e%0d", e));
        check_eq("rstmid_done_cnt", n_done, 0);

`ifdef DUAL_CLK_SCHED_HOLD_EN
        // hold on edges 5-9 shifts completion to edge 29
        clr_counts();
        set_cfg(2, 3, 24);
        step(1, 0, 0, 0, "hold_e0");
        for (int e = 1; e <= 31; e++) begin
            step(0, 0, (e >= 5 && e <= 9), 0, $sformatf("hold_e%0d", e));
            if (bus.o_done) done_edge = e;
        end
        check_eq("hold_done_edge", done_edge, 29);
        check_eq("hold_tick0_cnt", n_tick0, 11);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) set_cfg(0, $urandom_range(0, 5), $urandom_range(0, 40));
            else set_cfg($urandom_range(1, 5), $urandom_range(0, 5), $urandom_range(0, 40));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0,
                 $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dual_clk_sched.md
Name: dual_clk_sched

Overview:
- Programmable two-channel clock/tick scheduler for simulation and FPGA test rigs.
- Derives two divided square waves (clk_out0, clk_out1) from the single system clock, each with its own programmable half-period.
- Runs them for a programmed number of system cycles, then stops and signals completion.
- Replaces free-running delay-based clock generators with a synthesizable, start/stop-controlled sequencer.

Parameters:
CNT_W, 8, width of half-period inputs and per-channel counters
DUR_W, 16, width of duration input and elapsed-cycle counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high; clears all state on the next rising edge of clk
start  in  1  request a run; sampled only in IDLE
stop  in  1  abort a run; sampled in RUN (and HOLD)
half0  in  CNT_W  channel 0 half-period in clk cycles; latched on accepted start
half1  in  CNT_W  channel 1 half-period in clk cycles; latched on accepted start
duration  in  DUR_W  run length in clk cycles; latched on accepted start
clk_out0  out  1  channel 0 divided clock
clk_out1  out  1  channel 1 divided clock
tick0  out  1  one-cycle pulse on the edge where clk_out0 toggles
tick1  out  1  one-cycle pulse on the edge where clk_out1 toggles
busy  out  1  high while state is RUN or HOLD
done  out  1  one-cycle pulse after a run completes normally
err  out  1  one-cycle pulse when start is rejected for an invalid config

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. rst mid-run returns to IDLE on that edge, with no done pulse.
- All outputs are registered. States: IDLE, RUN, HOLD (HOLD exists only with the optional feature).
- IDLE, start=1, stop=0:
  - If half0, half1 and duration are all nonzero: latch half0_q, half1_q and dur_q; set cnt0<=half0-1, cnt1<=half1-1, elapsed<=0; state<=RUN.
  - If any of them is zero: err<=1 for one cycle; remain in IDLE.
- IDLE, start=1 and stop=1 in the same cycle: start ignored, no err.
- Number the accepting edge 0. Subsequent RUN edges are 1, 2, ...; busy is high from edge 0 through the final edge.
- Each RUN edge, channel n:
  - cnt_n==0: clk_out_n toggles, tick_n<=1, cnt_n<=half_n_q-1.
  - Otherwise: cnt_n decrements, tick_n<=0.
  - Result: clk_out_n toggles on edges k*half_n; period = 2*half_n cycles.
- elapsed increments every RUN edge. Final edge is the one where elapsed==dur_q-1, i.e. edge dur_q. On the final edge:
  - state<=IDLE; clk_out0/1<=0; tick0/1<=0 (no toggle, even if one was due); done<=1 for one cycle.
- Both channels due on the same edge: both toggle and both ticks assert together. There is no priority between channels.
- stop=1 in RUN: state<=IDLE, clk_outs<=0, ticks<=0, no done. stop takes priority over the final-edge completion.
- start during RUN or HOLD: ignored; latched config is unchanged.
- Input changes to half0, half1 or duration during a run have no effect.
- Counter wrap: elapsed never exceeds dur_q-1. half=1 gives toggling on every edge.

Optional Feature:
- Macro: DUAL_CLK_SCHED_HOLD_EN.
- With the macro defined:
  - Extra input port hold (1 bit).
  - RUN, hold=1, stop=0 -> HOLD. In HOLD, cnt0, cnt1 and elapsed are frozen, clk_outs keep their value, ticks are 0, and busy stays 1.
  - HOLD, hold=0 -> RUN. Counting resumes exactly where it stopped.
  - stop in HOLD -> IDLE, with the same clearing as stop in RUN.
  - Edges spent in HOLD do not count toward duration.
- Without the macro: no hold port, no HOLD state; the design is identical to the base behaviour.

Test Plan:
- Base run: rst 2 cycles, then start with half0=2, half1=3, duration=24.
  - clk_out0 toggles at edges 2,4,...,22 (11 tick0 pulses); clk_out1 toggles at 3,6,...,21 (7 tick1 pulses).
  - Edge 24: both clk_outs 0, done=1 for one cycle, busy falls.
- Coincident toggle: half0=2, half1=3, duration=20. At edge 6, tick0 and tick1 both assert and both clk_outs toggle.
- Invalid config: start with half1=0 -> err=1 for one cycle; busy stays 0; no toggles.
- Abort: half0=1, half1=4, duration=100, stop at edge 10 -> edge 10 returns IDLE, clk_outs 0, done never pulses. A start at edge 12 is accepted.
- Reset mid-run: rst at edge 7 of the base run -> all outputs 0 at edge 7; no done.
- With DUAL_CLK_SCHED_HOLD_EN, base run with hold high on edges 5-9:
  - Outputs frozen during the hold; ticks 0.
  - Remaining toggles shifted by 5; done at edge 29.
